traffic_ctrl: RTL



---
 rtl/traffic_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/traffic_ctrl.sv
// Two-approach (WE / NS) traffic-light controller with timed phases, all-red
// clearance, vehicle-actuated gap-out, rest-in-green and a flashing-yellow night mode.
module traffic_ctrl #(
    parameter int GREEN_T   = 40,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int MIN_GREEN = 10,
    parameter int CNT_W     = 8
) (
    input  logic             sec,
    input  logic             rst_n,
    input  logic             we,
    input  logic             ns,
    input  logic             flash,
    output logic [CNT_W-1:0] bits,
    output logic [5:0]       lights,
    output logic [2:0]       phase
);

    localparam logic [2:0] S_WE_G   = 3'd0;
    localparam logic [2:0] S_WE_Y   = 3'd1;
    localparam logic [2:0] S_AR1    = 3'd2;
    localparam logic [2:0] S_NS_G   = 3'd3;
    localparam logic [2:0] S_NS_Y   = 3'd4;
    localparam logic [2:0] S_AR2    = 3'd5;
    localparam logic [2:0] S_FLASH  = 3'd6;
    localparam logic [2:0] S_UNUSED = 3'd7;

    localparam logic [CNT_W-1:0] GREEN_C  = CNT_W'(GREEN_T);
    localparam logic [CNT_W-1:0] YELLOW_C = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] ALLRED_C = CNT_W'(ALLRED_T);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    // Countdown value at or below which the green has been shown for MIN_GREEN seconds.
    localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GREEN_T - MIN_GREEN + 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;
    logic [5:0]       lights_q;

    logic is_green, own_veh, cross_veh, gap_out;

    // Lamp order: {we_r, we_y, we_g, ns_r, ns_y, ns_g}.
    function automatic logic [5:0] lamps(input logic [2:0] st, input logic bl);
        case (st)
            S_WE_G:  lamps = 6'b001100;
            S_WE_Y:  lamps = 6'b010100;
            S_NS_G:  lamps = 6'b100001;
            S_NS_Y:  lamps = 6'b100010;
            S_FLASH: lamps = {1'b0, bl, 1'b0, 1'b0, bl, 1'b0};
            default: lamps = 6'b100100;
        endcase
    endfunction

    always_comb begin
        is_green  = (state_q == S_WE_G) || (state_q == S_NS_G);
        own_veh   = (state_q == S_WE_G) ? we : ns;
        cross_veh = (state_q == S_WE_G) ? ns : we;
        gap_out   = is_green && !own_veh && cross_veh && (cnt_q <= GAP_C);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (flash && (state_q != S_FLASH)) begin
            state_d = S_FLASH;
            cnt_d   = '0;
            blink_d = 1'b1;
        end else if (state_q == S_FLASH) begin
            if (flash) begin
                blink_d = ~blink_q;
            end else begin
                state_d = S_AR2;
                cnt_d   = ALLRED_C;
            end
        end else if (state_q == S_UNUSED) begin
            state_d = S_AR2;
            cnt_d   = ALLRED_C;
        end else if (gap_out) begin
            state_d = (state_q == S_WE_G) ? S_WE_Y : S_NS_Y;
            cnt_d   = YELLOW_C;
        end else if (cnt_q > ONE_C) begin
            cnt_d = cnt_q - ONE_C;
        end else begin
            // Expiry; a green with no waiting cross traffic rests and reloads.
            case (state_q)
                S_WE_G: begin
                    if (ns) begin
                        state_d = S_WE_Y;
                        cnt_d   = YELLOW_C;
                    end else begin
                        cnt_d = GREEN_C;
                    end
                end
                S_WE_Y: begin
                    state_d = S_AR1;
                    cnt_d   = ALLRED_C;
                end
                S_AR1: begin
                    state_d = S_NS_G;
                    cnt_d   = GREEN_C;
                end
                S_NS_G: begin
                    if (we) begin
                        state_d = S_NS_Y;
                        cnt_d   = YELLOW_C;
                    end else begin
                        cnt_d = GREEN_C;
                    end
                end
                S_NS_Y: begin
                    state_d = S_AR2;
                    cnt_d   = ALLRED_C;
                end
                default: begin
                    state_d = S_WE_G;
                    cnt_d   = GREEN_C;
                end
            endcase
        end
    end

    always_ff @(posedge sec or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_AR2;
            cnt_q    <= ALLRED_C;
            blink_q  <= 1'b1;
            lights_q <= 6'b100100;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            blink_q  <= blink_d;
            lights_q <= lamps(state_d, blink_d);
        end
    end

    assign phase  = state_q;
    assign bits   = cnt_q;
    assign lights = lights_q;

endmodule
